axi_slave_tag_tracker: RTL and testbench

//  Tracks outstanding non-posted AXI slave requests as PCIe tags. It is the parametrised successor of the

---
 rtl/axi_slave_tag_tracker.sv | 189 ++++++++++++++++++
 tb/tb_axi_slave_tag_tracker.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_tag_tracker.sv
// Outstanding non-posted AXI slave request tracker: lowest-free PCIe tag allocation,
// completion lookup, per-entry completion timeout and round-robin expiry reporting.
module axi_slave_tag_tracker #(
    parameter int unsigned NUM_TAGS       = 32,
    parameter int unsigned TAG_WIDTH      = $clog2(NUM_TAGS),
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned LEN_WIDTH      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                    axi_clk,
    input  logic                    ARESTn,
    input  logic                    alloc_req,
    input  logic                    alloc_is_rd,
    input  logic [AXI_ID_WIDTH-1:0] alloc_axi_id,
    input  logic [LEN_WIDTH-1:0]    alloc_len,
    output logic                    alloc_gnt,
    output logic [TAG_WIDTH-1:0]    alloc_tag,
    input  logic                    cpl_valid,
    input  logic [TAG_WIDTH-1:0]    cpl_tag,
    input  logic                    cpl_last,
    output logic                    cpl_hit,
    output logic                    cpl_unexp,
    output logic [AXI_ID_WIDTH-1:0] cpl_axi_id,
    output logic                    cpl_is_rd,
    output logic [LEN_WIDTH-1:0]    cpl_len,
    output logic                    to_valid,
    input  logic                    to_ready,
    output logic [TAG_WIDTH-1:0]    to_tag,
    output logic [AXI_ID_WIDTH-1:0] to_axi_id,
    output logic                    to_is_rd,
    output logic [LEN_WIDTH-1:0]    to_len,
    output logic [TAG_WIDTH:0]      outstanding,
    output logic                    full
);

    localparam int unsigned          OUT_WIDTH = TAG_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] TMR_LAST  = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {ST_FREE, ST_PEND, ST_EXP} ent_state_t;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0] axi_id;
        logic                    is_rd;
        logic [LEN_WIDTH-1:0]    len;
    } rec_t;

    ent_state_t           st_q  [NUM_TAGS];
    ent_state_t           st_d  [NUM_TAGS];
    logic [CNT_WIDTH-1:0] tmr_q [NUM_TAGS];
    logic [CNT_WIDTH-1:0] tmr_d [NUM_TAGS];
    rec_t                 rec_q [NUM_TAGS];

    logic [TAG_WIDTH-1:0] rr_last_q;
    logic                 free_found;
    logic [OUT_WIDTH-1:0] busy_cnt;
    logic                 exp_found;
    logic [TAG_WIDTH-1:0] exp_tag;
    logic                 cpl_free;
    logic                 to_fire;
    logic                 to_valid_d;
    logic [TAG_WIDTH-1:0] to_tag_d;
    rec_t                 to_rec_d;
    rec_t                 cpl_rec;

    // Lowest free entry and occupancy, both from registered state only
    always_comb begin
        free_found = 1'b0;
        alloc_tag  = '0;
        busy_cnt   = '0;
        for (int i = 0; i < int'(NUM_TAGS); i++) begin
            if (st_q[i] == ST_FREE) begin
                if (!free_found) begin
                    alloc_tag  = TAG_WIDTH'(i);
                    free_found = 1'b1;
                end
            end else begin
                busy_cnt = busy_cnt + OUT_WIDTH'(1);
            end
        end
    end

    assign outstanding = busy_cnt;
    assign full        = (busy_cnt == OUT_WIDTH'(NUM_TAGS));
    assign alloc_gnt   = alloc_req & ~full;

    assign cpl_rec    = rec_q[cpl_tag];
    assign cpl_hit    = cpl_valid & (st_q[cpl_tag] == ST_PEND);
    assign cpl_unexp  = cpl_valid & (st_q[cpl_tag] != ST_PEND);
    assign cpl_free   = cpl_hit & cpl_last;
    assign cpl_axi_id = cpl_rec.axi_id;
    assign cpl_is_rd  = cpl_rec.is_rd;
    assign cpl_len    = cpl_rec.len;

    assign to_fire = to_valid & to_ready;

    // Round-robin search for an expired entry, starting after the last one reported
    always_comb begin
        exp_found = 1'b0;
        exp_tag   = '0;
        for (int k = 1; k <= int'(NUM_TAGS); k++) begin
            if (!exp_found && st_q[(int'(rr_last_q) + k) % int'(NUM_TAGS)] == ST_EXP) begin
                exp_found = 1'b1;
                exp_tag   = TAG_WIDTH'((int'(rr_last_q) + k) % int'(NUM_TAGS));
            end
        end
    end

    // Per-entry next state and timeout report next state
    always_comb begin
        for (int i = 0; i < int'(NUM_TAGS); i++) begin
            st_d[i]  = st_q[i];
            tmr_d[i] = tmr_q[i];
        end
        to_valid_d = to_valid;
        to_tag_d   = to_tag;
        to_rec_d   = {to_axi_id, to_is_rd, to_len};

        for (int i = 0; i < int'(NUM_TAGS); i++) begin
            case (st_q[i])
                ST_FREE: begin
                    if (alloc_gnt && alloc_tag == TAG_WIDTH'(i)) begin
                        st_d[i]  = ST_PEND;
                        tmr_d[i] = '0;
                    end
                end
                ST_PEND: begin
                    // A final completion on the expiry cycle takes priority over the timeout
                    if (cpl_free && cpl_tag == TAG_WIDTH'(i)) begin
                        st_d[i]  = ST_FREE;
                        tmr_d[i] = '0;
                    end else if (tmr_q[i] == TMR_LAST) begin
                        st_d[i] = ST_EXP;
                    end else begin
                        tmr_d[i] = tmr_q[i] + CNT_WIDTH'(1);
                    end
                end
                ST_EXP: begin
                    if (to_fire && to_tag == TAG_WIDTH'(i)) begin
                        st_d[i]  = ST_FREE;
                        tmr_d[i] = '0;
                    end
                end
                default: st_d[i] = ST_FREE;
            endcase
        end

        if (to_fire) begin
            to_valid_d = 1'b0;
        end else if (!to_valid && exp_found) begin
            to_valid_d = 1'b1;
            to_tag_d   = exp_tag;
            to_rec_d   = rec_q[exp_tag];
        end
    end

    always_ff @(posedge axi_clk or negedge ARESTn) begin
        if (!ARESTn) begin
            for (int i = 0; i < int'(NUM_TAGS); i++) begin
                st_q[i]  <= ST_FREE;
                tmr_q[i] <= '0;
                rec_q[i] <= '0;
            end
            to_valid  <= 1'b0;
            to_tag    <= '0;
            to_axi_id <= '0;
            to_is_rd  <= 1'b0;
            to_len    <= '0;
            rr_last_q <= TAG_WIDTH'(NUM_TAGS - 1);
        end else begin
            for (int i = 0; i < int'(NUM_TAGS); i++) begin
                st_q[i]  <= st_d[i];
                tmr_q[i] <= tmr_d[i];
                if (alloc_gnt && alloc_tag == TAG_WIDTH'(i)) begin
                    rec_q[i] <= {alloc_axi_id, alloc_is_rd, alloc_len};
                end
            end
            to_valid  <= to_valid_d;
            to_tag    <= to_tag_d;
            to_axi_id <= to_rec_d.axi_id;
            to_is_rd  <= to_rec_d.is_rd;
            to_len    <= to_rec_d.len;
            if (to_valid_d && !to_valid) begin
                rr_last_q <= to_tag_d;
            end
        end
    end

endmodule

// File: tb/tb_axi_slave_tag_tracker.sv
// Self-checking bench for axi_slave_tag_tracker: directed scenarios plus random traffic
// checked against a per-tag state model driven by grant-cycle bookkeeping.
module tb_axi_slave_tag_tracker;

    localparam int unsigned NT = 8;
    localparam int unsigned TW = 3;
    localparam int unsigned IW = 4;
    localparam int unsigned LW = 8;
    localparam int unsigned TO = 16;

    logic          axi_clk = 1'b0;
    logic          ARESTn = 1'b0;
    logic          alloc_req = 1'b0;
    logic          alloc_is_rd = 1'b0;
    logic [IW-1:0] alloc_axi_id = '0;
    logic [LW-1:0] alloc_len = '0;
    logic          alloc_gnt;
    logic [TW-1:0] alloc_tag;
    logic          cpl_valid = 1'b0;
    logic [TW-1:0] cpl_tag = '0;
    logic          cpl_last = 1'b0;
    logic          cpl_hit;
    logic          cpl_unexp;
    logic [IW-1:0] cpl_axi_id;
    logic          cpl_is_rd;
    logic [LW-1:0] cpl_len;
    logic          to_valid;
    logic          to_ready = 1'b0;
    logic [TW-1:0] to_tag;
    logic [IW-1:0] to_axi_id;
    logic          to_is_rd;
    logic [LW-1:0] to_len;
    logic [TW:0]   outstanding;
    logic          full;

    axi_slave_tag_tracker #(
        .NUM_TAGS(NT), .TAG_WIDTH(TW), .AXI_ID_WIDTH(IW), .LEN_WIDTH(LW),
        .TIMEOUT_CYCLES(TO), .CNT_WIDTH($clog2(TO + 1))
    ) dut (
        .axi_clk(axi_clk), .ARESTn(ARESTn),
        .alloc_req(alloc_req), .alloc_is_rd(alloc_is_rd), .alloc_axi_id(alloc_axi_id),
        .alloc_len(alloc_len), .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag),
        .cpl_valid(cpl_valid), .cpl_tag(cpl_tag), .cpl_last(cpl_last),
        .cpl_hit(cpl_hit), .cpl_unexp(cpl_unexp), .cpl_axi_id(cpl_axi_id),
        .cpl_is_rd(cpl_is_rd), .cpl_len(cpl_len),
        .to_valid(to_valid), .to_ready(to_ready), .to_tag(to_tag), .to_axi_id(to_axi_id),
        .to_is_rd(to_is_rd), .to_len(to_len),
        .outstanding(outstanding), .full(full)
    );

    always #5 axi_clk = ~axi_clk;

    int n_chk = 0;
    int n_fail = 0;

    // Model: 0 free, 1 pending, 2 expired; grant edge number per tag
    int            mst  [NT];
    int            mgnt [NT];
    logic [IW-1:0] mid  [NT];
    logic          mrd  [NT];
    logic [LW-1:0] mlen [NT];
    int            cyc = 0;
    int            idle = 0;
    logic          hold_prev = 1'b0;
    logic [TW-1:0] hold_tag = '0;

    logic [TW-1:0] last_gnt_tag = '0;
    logic          last_cpl_hit = 1'b0;
    logic          last_cpl_unexp = 1'b0;
    logic [IW-1:0] last_cpl_id = '0;
    logic [LW-1:0] last_cpl_len = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int m_busy();
        int n = 0;
        for (int i = 0; i < int'(NT); i++) if (mst[i] != 0) n++;
        return n;
    endfunction

    function automatic int m_low_free();
        for (int i = 0; i < int'(NT); i++) if (mst[i] == 0) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(NT); i++) begin
            mst[i] = 0; mgnt[i] = 0; mid[i] = '0; mrd[i] = 1'b0; mlen[i] = '0;
        end
        cyc = 0; idle = 0; hold_prev = 1'b0;
    endtask

    // One clock cycle: check registered outputs, drive, check lookups, advance model
    task automatic step(input logic a_req, input logic a_rd, input logic [IW-1:0] a_id,
                        input logic [LW-1:0] a_len, input logic c_v, input logic [TW-1:0] c_tag,
                        input logic c_last, input logic t_rdy);
        int            lf;
        logic          exp_gnt;
        logic          pv;
        logic          any_exp;
        logic [TW-1:0] pt;
        check("outstanding", 32'(outstanding), 32'(m_busy()));
        check("full", 32'(full), 32'(m_busy() == int'(NT)));
        if (hold_prev) begin
            check("to_hold_valid", 32'(to_valid), 32'd1);
            check("to_hold_tag", 32'(to_tag), 32'(hold_tag));
        end
        if (to_valid) begin
            check("to_expired", 32'(mst[to_tag]), 32'd2);
            check("to_axi_id", 32'(to_axi_id), 32'(mid[to_tag]));
            check("to_is_rd", 32'(to_is_rd), 32'(mrd[to_tag]));
            check("to_len", 32'(to_len), 32'(mlen[to_tag]));
        end
        any_exp = 1'b0;
        for (int i = 0; i < int'(NT); i++) if (mst[i] == 2) any_exp = 1'b1;
        idle = (any_exp && !to_valid) ? idle + 1 : 0;
        check("to_latency", 32'(idle > 2), 32'd0);

        alloc_req = a_req; alloc_is_rd = a_rd; alloc_axi_id = a_id; alloc_len = a_len;
        cpl_valid = c_v; cpl_tag = c_tag; cpl_last = c_last; to_ready = t_rdy;
        #1;
        lf = m_low_free();
        exp_gnt = a_req && (lf >= 0);
        check("alloc_gnt", 32'(alloc_gnt), 32'(exp_gnt));
        if (exp_gnt) check("alloc_tag", 32'(alloc_tag), 32'(lf));
        if (c_v) begin
            check("cpl_hit", 32'(cpl_hit), 32'(mst[c_tag] == 1));
            check("cpl_unexp", 32'(cpl_unexp), 32'(mst[c_tag] != 1));
            if (mst[c_tag] == 1) begin
                check("cpl_axi_id", 32'(cpl_axi_id), 32'(mid[c_tag]));
                check("cpl_is_rd", 32'(cpl_is_rd), 32'(mrd[c_tag]));
                check("cpl_len", 32'(cpl_len), 32'(mlen[c_tag]));
            end
        end else begin
            check("cpl_quiet", 32'({cpl_hit, cpl_unexp}), 32'd0);
        end
        last_gnt_tag = alloc_tag;
        last_cpl_hit = cpl_hit; last_cpl_unexp = cpl_unexp;
        last_cpl_id = cpl_axi_id; last_cpl_len = cpl_len;
        pv = to_valid;
        pt = to_tag;

        @(posedge axi_clk);
        for (int i = 0; i < int'(NT); i++) begin
            if (mst[i] == 1) begin
                if (c_v && c_last && c_tag == TW'(i)) mst[i] = 0;
                else if (cyc - mgnt[i] == int'(TO)) mst[i] = 2;
            end
        end
        if (pv && t_rdy) mst[pt] = 0;
        if (exp_gnt) begin
            mst[lf] = 1; mgnt[lf] = cyc; mid[lf] = a_id; mrd[lf] = a_rd; mlen[lf] = a_len;
        end
        hold_prev = pv && !t_rdy;
        hold_tag = pt;
        cyc++;
        #1;
    endtask

    task automatic idle_n(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic alloc1(input logic rd, input logic [IW-1:0] id, input logic [LW-1:0] len);
        step(1'b1, rd, id, len, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic cpl1(input logic [TW-1:0] tag, input logic last);
        step(1'b0, 1'b0, '0, '0, 1'b1, tag, last, 1'b0);
    endtask

    // Asynchronous reset pulse between clock edges; all state must vanish immediately
    task automatic do_reset();
        alloc_req = 1'b0; cpl_valid = 1'b0; cpl_last = 1'b0; to_ready = 1'b0;
        alloc_is_rd = 1'b0; alloc_axi_id = '0; alloc_len = '0; cpl_tag = '0;
        #1 ARESTn = 1'b0;
        #1;
        check("rst_outstanding", 32'(outstanding), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_alloc", 32'({alloc_gnt, alloc_tag}), 32'd0);
        check("rst_cpl", 32'({cpl_hit, cpl_unexp, cpl_axi_id, cpl_is_rd, cpl_len}), 32'd0);
        check("rst_to", 32'({to_valid, to_tag, to_axi_id, to_is_rd, to_len}), 32'd0);
        @(negedge axi_clk);
        ARESTn = 1'b1;
        model_reset();
        @(posedge axi_clk);
        #1;
    endtask

    initial begin
        model_reset();
        do_reset();

        // Lowest-free allocation, fill to full, free tag 5 and reallocate it
        alloc1(1'b1, 4'd1, 8'd10); check("t1_tag_a", 32'(last_gnt_tag), 32'd0);
        alloc1(1'b0, 4'd2, 8'd20); check("t1_tag_b", 32'(last_gnt_tag), 32'd1);
        alloc1(1'b1, 4'd3, 8'd30); check("t1_tag_c", 32'(last_gnt_tag), 32'd2);
        idle_n(1);
        check("t1_outstanding", 32'(outstanding), 32'd3);
        check("t1_full", 32'(full), 32'd0);
        for (int k = 3; k < int'(NT); k++) alloc1(1'b0, IW'(k), LW'(k));
        check("t2_full", 32'(full), 32'd1);
        alloc1(1'b1, 4'd9, 8'd9);
        check("t2_no_gnt", 32'(alloc_gnt), 32'd0);
        cpl1(3'd5, 1'b1);
        alloc1(1'b1, 4'd12, 8'd12); check("t2_realloc", 32'(last_gnt_tag), 32'd5);
        do_reset();

        // Partial then final completion; a partial does not restart the timer
        alloc1(1'b1, 4'd7, 8'd3);
        alloc1(1'b0, 4'd9, 8'd0);
        idle_n(8);
        cpl1(3'd0, 1'b0);
        check("t3_hit_partial", 32'({last_cpl_hit, last_cpl_id, last_cpl_len}), 32'({1'b1, 4'd7, 8'd3}));
        cpl1(3'd1, 1'b0);
        idle_n(3);
        cpl1(3'd0, 1'b1);
        check("t3_hit_last", 32'({last_cpl_hit, last_cpl_id, last_cpl_len}), 32'({1'b1, 4'd7, 8'd3}));
        idle_n(2);
        cpl1(3'd1, 1'b1);
        check("t3_cpl_expired", 32'({last_cpl_hit, last_cpl_unexp}), 32'b01);
        cpl1(3'd4, 1'b1);
        check("t3_cpl_never", 32'({last_cpl_hit, last_cpl_unexp}), 32'b01);
        check("t3_outstanding", 32'(outstanding), 32'd1);
        check("t3_to_tag", 32'({to_valid, to_tag}), 32'({1'b1, 3'd1}));
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
        idle_n(2);
        check("t3_drained", 32'({to_valid, outstanding}), 32'd0);
        do_reset();

        // Two timeouts reported in order under back-pressure
        alloc1(1'b1, 4'd4, 8'd15);
        alloc1(1'b0, 4'd5, 8'd0);
        idle_n(14);
        cpl1(3'd0, 1'b0);
        check("t4_pend_before", 32'(last_cpl_hit), 32'd1);
        cpl1(3'd0, 1'b0);
        check("t4_exp_after", 32'({last_cpl_hit, last_cpl_unexp}), 32'b01);
        idle_n(6);
        check("t4_first", 32'({to_valid, to_tag}), 32'({1'b1, 3'd0}));
        check("t4_outstanding", 32'(outstanding), 32'd2);
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
        for (int w = 0; w < 5 && !to_valid; w++) idle_n(1);
        check("t4_second", 32'({to_valid, to_tag}), 32'({1'b1, 3'd1}));
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
        idle_n(2);
        check("t4_drained", 32'({to_valid, outstanding}), 32'd0);
        do_reset();

        // Final completion on the exact expiry cycle wins
        alloc1(1'b1, 4'd2, 8'd1);
        idle_n(15);
        cpl1(3'd0, 1'b1);
        check("t5_hit", 32'(last_cpl_hit), 32'd1);
        idle_n(3);
        check("t5_no_to", 32'({to_valid, outstanding}), 32'd0);

        // Reset with four pending entries
        for (int k = 0; k < 4; k++) alloc1(1'b0, IW'(k), LW'(k));
        check("t6_outstanding", 32'(outstanding), 32'd4);
        do_reset();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom), IW'($urandom), LW'($urandom),
                 $urandom_range(0, 2) == 0, TW'($urandom), 1'($urandom), $urandom_range(0, 2) == 0);
        end
        for (int n = 0; n < 40; n++) step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
        check("rand_drained", 32'(outstanding), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
